// File: rtl/ifetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, the instruction SRAM port and ID.
// master = ifetch_ctrl, slave = the SRAM/ID side.
// Optional feature macro: IFETCH_ADEL_CHECK_EN adds the if_adel signal.
interface ifetch_ctrl_if;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_stop;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
`ifdef IFETCH_ADEL_CHECK_EN
   logic        if_adel;
`endif

   modport master (
      output inst_sram_en, inst_sram_addr,
      input  inst_sram_rdata,
      input  redirect_valid, redirect_pc, fetch_stop, id_ready,
      output if_valid, if_pc, if_inst
`ifdef IFETCH_ADEL_CHECK_EN
      , output if_adel
`endif
   );

   modport slave (
      input  inst_sram_en, inst_sram_addr,
      output inst_sram_rdata,
      output redirect_valid, redirect_pc, fetch_stop, id_ready,
      input  if_valid, if_pc, if_inst
`ifdef IFETCH_ADEL_CHECK_EN
      , input if_adel
`endif
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one SRAM read per cycle,
// catches the 1-cycle-latency response and parks it in a 2-entry skid buffer
// toward ID. Redirects flush everything and restart fetch in the same cycle.
// Optional feature macro: IFETCH_ADEL_CHECK_EN (misaligned-PC address error
// entries, carried on if_adel, instead of an SRAM request).
module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input logic           clk,
   input logic           rst,
   ifetch_ctrl_if.master bus
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STOP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_next_q, pc_next_d;
   logic        inflight_q, inflight_d;
   logic [31:0] resp_pc_q, resp_pc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] e0_pc_q, e0_pc_d, e0_inst_q, e0_inst_d;
   logic [31:0] e1_pc_q, e1_pc_d, e1_inst_q, e1_inst_d;
`ifdef IFETCH_ADEL_CHECK_EN
   logic        resp_adel_q, resp_adel_d;
   logic        e0_adel_q, e0_adel_d, e1_adel_q, e1_adel_d;
`endif

   logic        if_valid_o;
   logic        pop;
   logic        push;
   logic [2:0]  occ;
   logic [31:0] req_pc;
   logic        want;
   logic        adel;
   logic        issue;
   logic [31:0] push_inst;

   // Request decision: redirect always fetches; otherwise issue only in RUN
   // when the buffer is guaranteed room for the response one cycle later.
   always_comb begin
      if_valid_o = (cnt_q != 2'd0) & ~bus.redirect_valid;
      pop        = if_valid_o & bus.id_ready;
      occ        = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
      req_pc     = bus.redirect_valid ? bus.redirect_pc : pc_next_q;
      want       = bus.redirect_valid |
                   ((state_q == ST_RUN) & ~bus.fetch_stop & (occ < 3'd2));
`ifdef IFETCH_ADEL_CHECK_EN
      adel       = want & (req_pc[1:0] != 2'b00);
`else
      adel       = 1'b0;
`endif
      issue      = want & ~adel;
   end

   assign bus.inst_sram_en   = issue;
   assign bus.inst_sram_addr = req_pc;
   assign bus.if_valid       = if_valid_o;
   assign bus.if_pc          = e0_pc_q;
   assign bus.if_inst        = e0_inst_q;
`ifdef IFETCH_ADEL_CHECK_EN
   assign bus.if_adel        = e0_adel_q;
`endif

   // FSM, PC and in-flight tracking next-state
   always_comb begin
      state_d = state_q;
      if (adel) begin
         state_d = ST_STOP;
      end else if (bus.redirect_valid) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (bus.fetch_stop) state_d = ST_STOP;
            default: state_d = state_q;
         endcase
      end

      pc_next_d = pc_next_q;
      if (bus.redirect_valid) begin
         pc_next_d = bus.redirect_pc + 32'd4;
      end else if (issue) begin
         pc_next_d = pc_next_q + 32'd4;
      end

      inflight_d = want;
      resp_pc_d  = want ? req_pc : resp_pc_q;
`ifdef IFETCH_ADEL_CHECK_EN
      resp_adel_d = adel;
`endif
   end

   // Skid buffer: entry 0 is the head; a response arriving during a redirect
   // is dropped along with the buffered words.
   always_comb begin
      push      = inflight_q & ~bus.redirect_valid;
`ifdef IFETCH_ADEL_CHECK_EN
      push_inst = resp_adel_q ? 32'd0 : bus.inst_sram_rdata;
`else
      push_inst = bus.inst_sram_rdata;
`endif
      cnt_d     = cnt_q;
      e0_pc_d   = e0_pc_q;
      e0_inst_d = e0_inst_q;
      e1_pc_d   = e1_pc_q;
      e1_inst_d = e1_inst_q;
`ifdef IFETCH_ADEL_CHECK_EN
      e0_adel_d = e0_adel_q;
      e1_adel_d = e1_adel_q;
`endif
      if (bus.redirect_valid) begin
         cnt_d = 2'd0;
      end else begin
         if (pop) begin
            e0_pc_d   = e1_pc_q;
            e0_inst_d = e1_inst_q;
`ifdef IFETCH_ADEL_CHECK_EN
            e0_adel_d = e1_adel_q;
`endif
         end
         if (push) begin
            if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
               e0_pc_d   = resp_pc_q;
               e0_inst_d = push_inst;
`ifdef IFETCH_ADEL_CHECK_EN
               e0_adel_d = resp_adel_q;
`endif
            end else begin
               e1_pc_d   = resp_pc_q;
               e1_inst_d = push_inst;
`ifdef IFETCH_ADEL_CHECK_EN
               e1_adel_d = resp_adel_q;
`endif
            end
         end
         cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // State registers; reset also clears the buffer and any in-flight response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_next_q  <= RESET_PC;
         inflight_q <= 1'b0;
         resp_pc_q  <= 32'd0;
         cnt_q      <= 2'd0;
         e0_pc_q    <= 32'd0;
         e0_inst_q  <= 32'd0;
         e1_pc_q    <= 32'd0;
         e1_inst_q  <= 32'd0;
`ifdef IFETCH_ADEL_CHECK_EN
         resp_adel_q <= 1'b0;
         e0_adel_q   <= 1'b0;
         e1_adel_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_next_q  <= pc_next_d;
         inflight_q <= inflight_d;
         resp_pc_q  <= resp_pc_d;
         cnt_q      <= cnt_d;
         e0_pc_q    <= e0_pc_d;
         e0_inst_q  <= e0_inst_d;
         e1_pc_q    <= e1_pc_d;
         e1_inst_q  <= e1_inst_d;
`ifdef IFETCH_ADEL_CHECK_EN
         resp_adel_q <= resp_adel_d;
         e0_adel_q   <= e0_adel_d;
         e1_adel_q   <= e1_adel_d;
`endif
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the fetch pipeline. The bench plays the
// SRAM: data for address a is mem(a), returned one cycle after the request.
module tb_ifetch_ctrl;

   logic clk;
   logic rst;
   ifetch_ctrl_if bus ();

   ifetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model state
   logic [31:0] m_pc;
   bit          m_booted, m_stopped, m_pend;
   logic [31:0] m_pend_pc;
   logic [63:0] m_q[$];

   // SRAM side: request seen last cycle
   bit          s_en;
   logic [31:0] s_addr;

   // Values observed in the most recent cycle, for directed checks
   logic        o_en, o_valid;
   logic [31:0] o_addr, o_pc;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'hBFC0_0000;
      m_booted = 0;
      m_stopped = 0;
      m_pend = 0;
      m_pend_pc = 32'd0;
      m_q.delete();
      s_en = 0;
      s_addr = 32'd0;
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_en"},    bus.inst_sram_en, 32'd0);
      chk({pfx, "_valid"}, bus.if_valid, 32'd0);
      chk({pfx, "_pc"},    bus.if_pc, 32'd0);
      chk({pfx, "_inst"},  bus.if_inst, 32'd0);
   endtask

   // One clock cycle: entered 1 time unit after a rising edge.
   task automatic cycle(input bit redir, input logic [31:0] rpc, input bit stop, input bit rdy);
      bit          vis, pop, exp_en;
      int          occ;
      logic [31:0] exp_addr;
      bus.redirect_valid  = redir;
      bus.redirect_pc     = rpc;
      bus.fetch_stop      = stop;
      bus.id_ready        = rdy;
      bus.inst_sram_rdata = s_en ? mem(s_addr) : $urandom;
      vis      = (m_q.size() != 0) && !redir;
      pop      = vis && rdy;
      occ      = m_q.size() + int'(m_pend) - int'(pop);
      exp_en   = redir || (m_booted && !m_stopped && !stop && occ < 2);
      exp_addr = redir ? rpc : m_pc;
      @(negedge clk);
      chk("en", bus.inst_sram_en, exp_en);
      if (exp_en) chk("addr", bus.inst_sram_addr, exp_addr);
      chk("if_valid", bus.if_valid, vis);
      if (vis) begin
         chk("if_pc", bus.if_pc, m_q[0][63:32]);
         chk("if_inst", bus.if_inst, m_q[0][31:0]);
      end
      o_en    = bus.inst_sram_en;
      o_addr  = bus.inst_sram_addr;
      o_valid = bus.if_valid;
      o_pc    = bus.if_pc;
      if (redir) begin
         m_q.delete();
         m_pend    = 1;
         m_pend_pc = rpc;
         m_pc      = rpc + 32'd4;
         m_booted  = 1;
         m_stopped = 0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (m_pend) m_q.push_back({m_pend_pc, mem(m_pend_pc)});
         m_pend = exp_en;
         if (exp_en) begin
            m_pend_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end
         if (!m_booted) m_booted = 1;
         else if (stop) m_stopped = 1;
      end
      s_en   = exp_en;
      s_addr = exp_addr;
      @(posedge clk);
      #1;
   endtask

   task automatic random_cycles(input int n);
      logic [31:0] r, rpc;
      bit          redir, stop, rdy;
      for (int i = 0; i < n; i++) begin
         r     = $urandom;
         rpc   = r & 32'hFFFF_FFFC;
         if (r[3:0] == 4'd0) rpc = 32'hFFFF_FFF0;
         redir = ($urandom_range(0, 99) < 5);
         stop  = ($urandom_range(0, 99) < 6);
         rdy   = ($urandom_range(0, 99) < 70);
         cycle(redir, rpc, stop, rdy);
      end
   endtask

   initial begin
      clk = 0;
      rst = 1;
      bus.inst_sram_rdata = 32'd0;
      bus.redirect_valid  = 0;
      bus.redirect_pc     = 32'd0;
      bus.fetch_stop      = 0;
      bus.id_ready        = 0;
      model_reset();

      // Power-on reset
      @(posedge clk);
      #1;
      chk_reset_outputs("por");
      @(posedge clk);
      #1;
      rst = 0;

      // Boot sequence: request in cycle 2, first delivery in cycle 4
      cycle(0, 32'd0, 0, 1);
      chk("boot_c1_en", o_en, 32'd0);
      cycle(0, 32'd0, 0, 1);
      chk("boot_c2_en", o_en, 32'd1);
      chk("boot_c2_addr", o_addr, 32'hBFC0_0000);
      cycle(0, 32'd0, 0, 1);
      chk("boot_c3_addr", o_addr, 32'hBFC0_0004);
      cycle(0, 32'd0, 0, 1);
      chk("boot_c4_valid", o_valid, 32'd1);
      chk("boot_c4_pc", o_pc, 32'hBFC0_0000);
      repeat (6) cycle(0, 32'd0, 0, 1);

      // ID back-pressure for 5 cycles, then resume
      repeat (5) cycle(0, 32'd0, 0, 0);
      chk("stall_en", o_en, 32'd0);
      chk("stall_valid", o_valid, 32'd1);
      repeat (8) cycle(0, 32'd0, 0, 1);

      // Redirect while the buffer is full
      repeat (3) cycle(0, 32'd0, 0, 0);
      cycle(1, 32'hBFC0_0100, 0, 1);
      chk("redir_en", o_en, 32'd1);
      chk("redir_addr", o_addr, 32'hBFC0_0100);
      chk("redir_valid", o_valid, 32'd0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 32'd0, 0, 1);
         if (o_valid) break;
      end
      chk("redir_first_pc", o_pc, 32'hBFC0_0100);
      cycle(0, 32'd0, 0, 1);
      chk("redir_second_pc", o_pc, 32'hBFC0_0104);
      repeat (3) cycle(0, 32'd0, 0, 1);

      // Fetch stop with a request in flight, then redirect restarts fetch
      for (int i = 0; i < 5; i++) begin
         cycle(0, 32'd0, 1, 1);
         chk("stop_no_en", o_en, 32'd0);
      end
      cycle(1, 32'hBFC0_0200, 1, 1);
      chk("stop_redir_addr", o_addr, 32'hBFC0_0200);
      cycle(0, 32'd0, 0, 1);
      chk("stop_resume_en", o_en, 32'd1);
      chk("stop_resume_addr", o_addr, 32'hBFC0_0204);
      repeat (4) cycle(0, 32'd0, 0, 1);

      // Address wrap at the top of the address space
      cycle(1, 32'hFFFF_FFFC, 0, 1);
      chk("wrap_redir_addr", o_addr, 32'hFFFF_FFFC);
      cycle(0, 32'd0, 0, 1);
      chk("wrap_en", o_en, 32'd1);
      chk("wrap_addr", o_addr, 32'h0000_0000);
      repeat (4) cycle(0, 32'd0, 0, 1);

      // Random traffic
      random_cycles(400);

      // Asynchronous reset in the middle of operation
      bus.redirect_valid = 0;
      bus.fetch_stop     = 0;
      bus.id_ready       = 1;
      #2;
      rst = 1;
      #1;
      chk_reset_outputs("mid");
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 0;
      cycle(0, 32'd0, 0, 1);
      cycle(0, 32'd0, 0, 1);
      chk("mid_restart_addr", o_addr, 32'hBFC0_0000);
      random_cycles(300);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
